// File: rtl/filter_sched_pkg.sv
// rtl/filter_sched_pkg.sv - shared types and defaults for the filter scheduler
package filter_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   localparam int CH0_ADS1 = 0;
   localparam int CH1_ADS1 = 1;
   localparam int CH0_ADS2 = 2;
   localparam int CH1_ADS2 = 3;

   localparam int DEF_DW           = 16;
   localparam int DEF_NCH          = 4;
   localparam int DEF_TEMPLATE_LEN = 64;

endpackage

// File: rtl/filter_scheduler_rr_arbiter.sv
// rtl/filter_scheduler_rr_arbiter.sv - combinational round-robin picker
// Returns the first requesting channel searching upward from ptr+1 (mod NCH).
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [CW-1:0]  idx
);

   int j;

   // Scan from the farthest candidate down so the nearest request is written last and wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      j     = 0;
      for (int k = NCH; k >= 1; k--) begin
         j = (int'(ptr) + k) % NCH;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = CW'(j);
         end
      end
   end

endmodule

// File: rtl/filter_scheduler.sv
// rtl/filter_scheduler.sv - shares one filter engine among four ADC channels
// Buffers one sample per channel, grants round-robin, loads templates and routes results.
module filter_scheduler
   import filter_sched_pkg::*;
#(
   parameter int DW           = DEF_DW,
   parameter int NCH          = DEF_NCH,
   parameter int TEMPLATE_LEN = DEF_TEMPLATE_LEN,
   parameter int AW           = 6,
   parameter int TIMEOUT      = 1023,
   parameter int CW           = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] Ch_Data,
   input  logic [NCH-1:0]    Ch_Data_en,
   input  logic [DW-1:0]     Data_template,
   input  logic              Data_template_en,
   output logic              eng_start,
   output logic [CW-1:0]     eng_ch,
   output logic [DW-1:0]     eng_data,
   input  logic              eng_done,
   input  logic [DW-1:0]     eng_result,
   input  logic              eng_sign,
   output logic              coef_we,
   output logic [AW-1:0]     coef_addr,
   output logic [DW-1:0]     coef_data,
   output logic [NCH*DW-1:0] Dataf,
   output logic [NCH-1:0]    Dataf_en,
   output logic [NCH-1:0]    Dataf_sign,
   output logic [NCH-1:0]    ovr_flag,
   output logic              tmpl_drop,
   output logic              eng_timeout,
   input  logic              flag_clr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [DW-1:0]   hold [NCH];
   logic [NCH-1:0]  pend;
   logic [CW-1:0]   ptr;
   logic [AW-1:0]   tcount;
   logic [TW-1:0]   wait_cnt;
   logic [NCH-1:0]  arb_grant;
   logic [CW-1:0]   arb_idx;
   logic            grant_ok;
   logic [NCH-1:0]  granted;
   logic            drop_set;
   logic            tmo_set;

   rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
      .req   (pend),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   // A template strobe in IDLE pre-empts any grant that cycle.
   assign grant_ok = (state == ST_IDLE) && (|pend) && !Data_template_en;
   assign granted  = grant_ok ? arb_grant : '0;
   assign drop_set = (state == ST_RUN) && Data_template_en;
   assign tmo_set  = (state == ST_RUN) && !eng_done && (wait_cnt == TW'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= '0;
         ovr_flag <= '0;
         for (int i = 0; i < NCH; i++) hold[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (Ch_Data_en[i]) begin
               hold[i] <= Ch_Data[i*DW +: DW];
               pend[i] <= 1'b1;
            end else if (granted[i]) begin
               pend[i] <= 1'b0;
            end
         end
         if (flag_clr) ovr_flag <= '0;
         else          ovr_flag <= ovr_flag | (Ch_Data_en & pend & ~granted);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         tcount      <= '0;
         wait_cnt    <= '0;
         eng_start   <= 1'b0;
         eng_ch      <= '0;
         eng_data    <= '0;
         coef_we     <= 1'b0;
         coef_addr   <= '0;
         coef_data   <= '0;
         Dataf       <= '0;
         Dataf_en    <= '0;
         Dataf_sign  <= '0;
         tmpl_drop   <= 1'b0;
         eng_timeout <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         coef_we   <= 1'b0;
         Dataf_en  <= '0;
         case (state)
            ST_IDLE: begin
               if (Data_template_en) begin
                  coef_we   <= 1'b1;
                  coef_addr <= '0;
                  coef_data <= Data_template;
                  tcount    <= AW'(1);
                  state     <= ST_LOAD;
               end else if (grant_ok) begin
                  eng_start <= 1'b1;
                  eng_ch    <= arb_idx;
                  eng_data  <= hold[arb_idx];
                  ptr       <= arb_idx;
                  wait_cnt  <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_LOAD: begin
               if (Data_template_en) begin
                  coef_we   <= 1'b1;
                  coef_addr <= tcount;
                  coef_data <= Data_template;
                  if (tcount == AW'(TEMPLATE_LEN - 1)) begin
                     tcount <= '0;
                     state  <= ST_IDLE;
                  end else begin
                     tcount <= tcount + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (eng_done) begin
                  Dataf[eng_ch*DW +: DW] <= eng_result;
                  Dataf_sign[eng_ch]     <= eng_sign;
                  Dataf_en[eng_ch]       <= 1'b1;
                  state                  <= ST_IDLE;
               end else if (tmo_set) begin
                  state <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (flag_clr) begin
            tmpl_drop   <= 1'b0;
            eng_timeout <= 1'b0;
         end else begin
            if (drop_set) tmpl_drop   <= 1'b1;
            if (tmo_set)  eng_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_filter_scheduler.sv
// tb/tb_filter_scheduler.sv - directed self-checking bench for filter_scheduler
module tb_filter_scheduler;
   import filter_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] Ch_Data;
   logic [3:0]  Ch_Data_en;
   logic [15:0] Data_template;
   logic        Data_template_en;
   logic        eng_start;
   logic [1:0]  eng_ch;
   logic [15:0] eng_data;
   logic        eng_done;
   logic [15:0] eng_result;
   logic        eng_sign;
   logic        coef_we;
   logic [5:0]  coef_addr;
   logic [15:0] coef_data;
   logic [63:0] Dataf;
   logic [3:0]  Dataf_en;
   logic [3:0]  Dataf_sign;
   logic [3:0]  ovr_flag;
   logic        tmpl_drop;
   logic        eng_timeout;
   logic        flag_clr;

   int n_cmp = 0;
   int n_bad = 0;
   logic saw;

   filter_scheduler dut (
      .clk(clk), .rst(rst), .Ch_Data(Ch_Data), .Ch_Data_en(Ch_Data_en),
      .Data_template(Data_template), .Data_template_en(Data_template_en),
      .eng_start(eng_start), .eng_ch(eng_ch), .eng_data(eng_data),
      .eng_done(eng_done), .eng_result(eng_result), .eng_sign(eng_sign),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .Dataf(Dataf), .Dataf_en(Dataf_en), .Dataf_sign(Dataf_sign),
      .ovr_flag(ovr_flag), .tmpl_drop(tmpl_drop), .eng_timeout(eng_timeout),
      .flag_clr(flag_clr)
   );

   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (eng_start !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 64'(n < 50), 64'd1);
   endtask

   task automatic start_job(input int ch, input logic [15:0] d);
      Ch_Data[ch*16 +: 16] = d;
      Ch_Data_en[ch] = 1'b1;
      tick();
      Ch_Data_en = '0;
      tick();
      chk("start_pulse", eng_start, 1);
      chk("start_ch", eng_ch, 64'(ch));
      chk("start_data", eng_data, d);
   endtask

   task automatic finish_job(input int ch, input logic [15:0] res, input logic s);
      eng_done = 1'b1;
      eng_result = res;
      eng_sign = s;
      tick();
      eng_done = 1'b0;
      chk("res_en", Dataf_en, 64'(4'b0001 << ch));
      chk("res_data", Dataf[ch*16 +: 16], res);
      chk("res_sign", Dataf_sign[ch], s);
   endtask

   initial begin
      rst = 1'b1;
      Ch_Data = '0; Ch_Data_en = '0; Data_template = '0; Data_template_en = 1'b0;
      eng_done = 1'b0; eng_result = '0; eng_sign = 1'b0; flag_clr = 1'b0;
      tick(); tick();
      chk("rst_start", eng_start, 0);
      chk("rst_ch", eng_ch, 0);
      chk("rst_data", eng_data, 0);
      chk("rst_coef", {coef_we, coef_addr, coef_data}, 0);
      chk("rst_dataf", Dataf, 0);
      chk("rst_flags", {Dataf_en, Dataf_sign, ovr_flag, tmpl_drop, eng_timeout}, 0);
      rst = 1'b0;
      tick();

      // single sample on ch2, exact 2-cycle latency
      start_job(CH0_ADS2, 16'h1234);
      tick();
      chk("start_one_cycle", eng_start, 0);
      tick();
      finish_job(CH0_ADS2, 16'h00FF, 1'b1);
      chk("t1_sign_vec", Dataf_sign, 4'b0100);
      tick();
      chk("dataf_en_pulse", Dataf_en, 0);
      chk("dataf_held", Dataf[47:32], 16'h00FF);
      eng_done = 1'b1; eng_result = 16'hDEAD; tick(); eng_done = 1'b0;
      chk("done_idle_ignored", Dataf_en, 0);
      chk("done_idle_nodata", Dataf[47:32], 16'h00FF);

      // one ch3 job puts ptr at 3, then a four-way burst
      start_job(CH1_ADS2, 16'h0333);
      tick(); tick();
      finish_job(CH1_ADS2, 16'h0033, 1'b0);
      Ch_Data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      Ch_Data_en = 4'hF;
      tick();
      Ch_Data_en = '0;
      for (int k = 0; k < 4; k++) begin
         wait_start("burst_wait");
         chk("burst_ch", eng_ch, 64'(k));
         chk("burst_data", eng_data, 64'(16'h1000 + k));
         tick(); tick();
         finish_job(k, 16'(16'h2000 + k), k[0]);
      end
      Ch_Data[15:0] = 16'h3000; Ch_Data[47:32] = 16'h3002;
      Ch_Data_en = 4'b0101;
      tick();
      Ch_Data_en = '0;
      wait_start("wrap_wait");
      chk("wrap_first_ch0", eng_ch, 0);
      tick(); finish_job(0, 16'h3100, 1'b0);
      wait_start("wrap_wait2");
      chk("wrap_second_ch2", eng_ch, 2);
      tick(); finish_job(2, 16'h3102, 1'b1);

      // new sample arriving on the grant cycle is not an overrun
      Ch_Data[15:0] = 16'h4000; Ch_Data_en = 4'b0001;
      tick();
      Ch_Data[15:0] = 16'h4001;
      tick();
      Ch_Data_en = '0;
      chk("grant_en_start", eng_start, 1);
      chk("grant_en_olddata", eng_data, 16'h4000);
      chk("grant_en_noovr", ovr_flag, 0);
      tick(); finish_job(0, 16'h4100, 1'b0);
      wait_start("grant_en_wait");
      chk("grant_en_newdata", eng_data, 16'h4001);
      tick(); finish_job(0, 16'h4101, 1'b0);

      // overrun on ch1 while engine busy
      start_job(CH1_ADS2, 16'h5003);
      Ch_Data[31:16] = 16'hAAAA; Ch_Data_en = 4'b0010;
      tick();
      Ch_Data[31:16] = 16'hBBBB;
      tick();
      Ch_Data_en = '0;
      chk("ovr_set", ovr_flag, 4'b0010);
      finish_job(CH1_ADS2, 16'h5103, 1'b0);
      wait_start("ovr_wait");
      chk("ovr_ch", eng_ch, 1);
      chk("ovr_newest", eng_data, 16'hBBBB);
      tick(); finish_job(1, 16'h5101, 1'b1);
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      chk("ovr_clr", ovr_flag, 0);

      // template load with a ch0 sample arriving mid-load
      saw = 1'b0;
      for (int i = 0; i < 64; i++) begin
         Data_template = 16'(i);
         Data_template_en = 1'b1;
         if (i == 10) begin
            Ch_Data[15:0] = 16'h0C0C;
            Ch_Data_en = 4'b0001;
         end
         tick();
         Ch_Data_en = '0;
         if (eng_start) saw = 1'b1;
         chk("load_we", coef_we, 1);
         chk("load_addr", coef_addr, 64'(i));
         chk("load_data", coef_data, 64'(i));
      end
      Data_template_en = 1'b0;
      chk("load_no_grant", saw, 0);
      tick();
      chk("post_load_we", coef_we, 0);
      chk("post_load_start", eng_start, 1);
      chk("post_load_ch", eng_ch, 0);
      chk("post_load_data", eng_data, 16'h0C0C);
      tick(); finish_job(0, 16'h0ABC, 1'b0);

      // timeout, template drop, and done winning at the timeout boundary
      start_job(CH0_ADS2, 16'h6002);
      Ch_Data[31:16] = 16'h6001; Ch_Data_en = 4'b0010;
      Data_template = 16'h9999; Data_template_en = 1'b1;
      tick();
      Ch_Data_en = '0; Data_template_en = 1'b0;
      chk("drop_flag", tmpl_drop, 1);
      chk("drop_no_we", coef_we, 0);
      repeat (1022) tick();
      chk("tmo_not_yet", eng_timeout, 0);
      tick();
      chk("tmo_set", eng_timeout, 1);
      chk("tmo_no_result", Dataf_en, 0);
      tick();
      chk("tmo_next_start", eng_start, 1);
      chk("tmo_next_ch", eng_ch, 1);
      chk("tmo_next_data", eng_data, 16'h6001);
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      chk("clr_tmo", eng_timeout, 0);
      chk("clr_drop", tmpl_drop, 0);
      repeat (1022) tick();
      finish_job(1, 16'h7777, 1'b0);
      chk("done_beats_tmo", eng_timeout, 0);

      // async reset mid-RUN and mid-LOAD
      start_job(CH1_ADS2, 16'h8003);
      rst = 1'b1;
      #1;
      chk("rst_run_start", eng_start, 0);
      chk("rst_run_ch_data", {eng_ch, eng_data}, 0);
      chk("rst_run_dataf", {Dataf, Dataf_sign}, 0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("rst_run_no_resume", eng_start, 0);
      for (int i = 0; i < 5; i++) begin
         Data_template = 16'(16'h50 + i);
         Data_template_en = 1'b1;
         tick();
      end
      Data_template_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_load_coef", {coef_we, coef_addr, coef_data}, 0);
      tick();
      rst = 1'b0;
      Data_template = 16'h0077; Data_template_en = 1'b1;
      tick();
      Data_template_en = 1'b0;
      chk("fresh_load_we", coef_we, 1);
      chk("fresh_load_addr", coef_addr, 0);
      chk("fresh_load_data", coef_data, 16'h0077);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
